// File: rtl/data_mem_sync_pkg.sv
// Shared definitions for the clocked data memory: access-size codes and FSM states.
package data_mem_pkg;

  // Access size field BHW of req_ctrl = {BHW[1:0], U}
  localparam logic [1:0] BHW_BYTE = 2'b00;
  localparam logic [1:0] BHW_HALF = 2'b01;
  localparam logic [1:0] BHW_WORD = 2'b10;
  localparam logic [1:0] BHW_ILL  = 2'b11;

  // Reset clear sweep, then normal operation
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

endpackage

// File: rtl/data_mem_sync_lane_align.sv
// Combinational lane steering for the data memory.
// Store side merges byte/half/word data into the old word and flags misalignment;
// load side extracts the addressed lane(s) and sign/zero extends to 32 bits.
module mem_lane_align
  import data_mem_pkg::*;
(
  input  logic [31:0] st_old,
  input  logic [31:0] st_wdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  bhw,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_word,
  output logic [31:0] st_merged,
  output logic        misalign,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Alignment / legality of the access size against the byte lane
  always_comb begin
    misalign = 1'b0;
    case (bhw)
      BHW_BYTE: misalign = 1'b0;
      BHW_HALF: misalign = lane[0];
      BHW_WORD: misalign = (lane != 2'b00);
      default:  misalign = 1'b1;
    endcase
  end

  // Merge store data into the addressed lane(s), keeping the other lanes
  always_comb begin
    st_merged = st_old;
    case (bhw)
      BHW_BYTE: begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (32'(lane) == i) st_merged[8*i +: 8] = st_wdata[7:0];
        end
      end
      BHW_HALF: begin
        if (lane[1]) st_merged[31:16] = st_wdata[15:0];
        else         st_merged[15:0]  = st_wdata[15:0];
      end
      BHW_WORD: st_merged = st_wdata;
      default:  st_merged = st_old;
    endcase
  end

  // Select the addressed byte and half of the loaded word
  always_comb begin
    ld_byte = ld_word[7:0];
    case (lane)
      2'd0:    ld_byte = ld_word[7:0];
      2'd1:    ld_byte = ld_word[15:8];
      2'd2:    ld_byte = ld_word[23:16];
      default: ld_byte = ld_word[31:24];
    endcase
    ld_half = lane[1] ? ld_word[31:16] : ld_word[15:0];
  end

  // Extend the extracted data to 32 bits; word ignores U
  always_comb begin
    ld_data = '0;
    case (bhw)
      BHW_BYTE: ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
      BHW_HALF: ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
      BHW_WORD: ld_data = ld_word;
      default:  ld_data = '0;
    endcase
  end

endmodule

// File: rtl/data_mem_sync.sv
// Clocked data memory between the MEM stage and the RAM array.
// Valid/ready request handshake, 1-cycle registered response, reset clear sweep,
// error flag for misaligned, out-of-range and illegal-size accesses.
module data_mem_sync
  import data_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int DEPTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]            req_ctrl,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]           mem [DEPTH];
  state_t                state;
  logic [IDX_W-1:0]      clr_idx;

  logic [ADDR_WIDTH-3:0] word_idx;
  logic [IDX_W-1:0]      mem_idx;
  logic [31:0]           rd_word;
  logic [31:0]           st_merged;
  logic [31:0]           ld_data;
  logic                  misalign;
  logic                  range_err;
  logic                  req_err;
  logic                  accept;
  logic                  do_store;

  assign req_ready = (state == ST_RUN);
  assign accept    = req_valid & req_ready & ~rst;

  assign word_idx  = req_addr[ADDR_WIDTH-1:2];
  assign mem_idx   = word_idx[IDX_W-1:0];
  assign range_err = (32'(word_idx) >= 32'(DEPTH));
  assign req_err   = misalign | range_err;
  assign do_store  = accept & req_we & ~req_err;

  // Asynchronous array read; only consumed when the index is in range
  assign rd_word = mem[mem_idx];

  mem_lane_align u_align (
    .st_old      (rd_word),
    .st_wdata    (req_wdata),
    .lane        (req_addr[1:0]),
    .bhw         (req_ctrl[2:1]),
    .ld_unsigned (req_ctrl[0]),
    .ld_word     (rd_word),
    .st_merged   (st_merged),
    .misalign    (misalign),
    .ld_data     (ld_data)
  );

  // Clear sweep sequencing: CLEAR for DEPTH cycles after reset, then RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_CLEAR;
      clr_idx <= '0;
    end else if (state == ST_CLEAR) begin
      if (clr_idx == IDX_W'(DEPTH - 1)) state <= ST_RUN;
      else                              clr_idx <= clr_idx + 1'b1;
    end
  end

  // Array writes: zero fill during the sweep, merged store data in RUN
  always_ff @(posedge clk) begin
    if (!rst && state == ST_CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (do_store) begin
      mem[mem_idx] <= st_merged;
    end
  end

  // Registered response; rdata holds when no request was accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (accept) begin
      resp_valid <= 1'b1;
      resp_err   <= req_err;
      resp_rdata <= (req_err || req_we) ? '0 : ld_data;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_mem_sync.sv
// Scoreboard bench for data_mem_sync: a byte-addressed reference model predicts each
// response at issue time; per-DUT monitors pop and compare on resp_valid.
module tb_data_mem_sync;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } resp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Main instance (DEPTH 32) signals
  logic        a_valid, a_ready, a_we, a_rvalid, a_rerr;
  logic [6:0]  a_addr;
  logic [2:0]  a_ctrl;
  logic [31:0] a_wdata, a_rdata;

  // Small instance (DEPTH 16) for range errors
  logic        b_valid, b_ready, b_we, b_rvalid, b_rerr;
  logic [6:0]  b_addr;
  logic [2:0]  b_ctrl;
  logic [31:0] b_wdata, b_rdata;

  int checks = 0;
  int errors = 0;

  resp_t q0[$];
  resp_t q1[$];
  bit [7:0] m0 [128];
  bit [7:0] m1 [128];

  data_mem_sync #(.ADDR_WIDTH(7), .DEPTH(32)) dut (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready), .req_we(a_we),
    .req_addr(a_addr), .req_ctrl(a_ctrl), .req_wdata(a_wdata),
    .resp_valid(a_rvalid), .resp_rdata(a_rdata), .resp_err(a_rerr)
  );

  data_mem_sync #(.ADDR_WIDTH(7), .DEPTH(16)) dut16 (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
    .req_addr(b_addr), .req_ctrl(b_ctrl), .req_wdata(b_wdata),
    .resp_valid(b_rvalid), .resp_rdata(b_rdata), .resp_err(b_rerr)
  );

  task automatic clear_model();
    for (int i = 0; i < 128; i++) begin
      m0[i] = 8'h00;
      m1[i] = 8'h00;
    end
  endtask

  // Little-endian byte memory model of one access
  task automatic model(input bit sel, input bit we, input int addr, input bit [2:0] ctrl,
                       input bit [31:0] wd, output resp_t r);
    int n;
    int depth;
    bit [31:0] v;
    depth = sel ? 16 : 32;
    r = '0;
    case (ctrl[2:1])
      2'b00:   n = 1;
      2'b01:   n = 2;
      2'b10:   n = 4;
      default: n = 0;
    endcase
    if (n == 0 || (addr % n) != 0 || (addr / 4) >= depth) begin
      r.err = 1'b1;
      return;
    end
    if (we) begin
      for (int i = 0; i < n; i++) begin
        if (sel) m1[addr+i] = wd[8*i +: 8];
        else     m0[addr+i] = wd[8*i +: 8];
      end
    end else begin
      v = 0;
      for (int i = 0; i < n; i++)
        v = v | ((sel ? 32'(m1[addr+i]) : 32'(m0[addr+i])) << (8*i));
      if (!ctrl[0] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      r.data = v;
    end
  endtask

  // Drive one request for a cycle; predict the response if it will be accepted
  task automatic issue(input bit sel, input bit we, input bit [6:0] addr, input bit [2:0] ctrl,
                       input bit [31:0] wd);
    resp_t r;
    if (sel) begin
      b_valid = 1'b1; b_we = we; b_addr = addr; b_ctrl = ctrl; b_wdata = wd;
      if (b_ready) begin model(1'b1, we, int'(addr), ctrl, wd, r); q1.push_back(r); end
    end else begin
      a_valid = 1'b1; a_we = we; a_addr = addr; a_ctrl = ctrl; a_wdata = wd;
      if (a_ready) begin model(1'b0, we, int'(addr), ctrl, wd, r); q0.push_back(r); end
    end
    @(posedge clk); #1;
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic check(input string name, input bit [31:0] act, input bit [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Count cycles from rst deassertion until req_ready rises
  task automatic ready_delay(output int n);
    n = 0;
    while (!a_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  always @(negedge clk) begin : mon0
    resp_t e;
    if (a_rvalid === 1'b1) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL resp0_unexpected actual=err%0d/0x%08h required=no response", a_rerr, a_rdata);
      end else begin
        e = q0.pop_front();
        if ({a_rerr, a_rdata} !== {e.err, e.data}) begin
          errors++;
          $display("FAIL resp0 actual=err%0d/0x%08h required=err%0d/0x%08h",
                   a_rerr, a_rdata, e.err, e.data);
        end
      end
    end
  end

  always @(negedge clk) begin : mon1
    resp_t e;
    if (b_rvalid === 1'b1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL resp1_unexpected actual=err%0d/0x%08h required=no response", b_rerr, b_rdata);
      end else begin
        e = q1.pop_front();
        if ({b_rerr, b_rdata} !== {e.err, e.data}) begin
          errors++;
          $display("FAIL resp1 actual=err%0d/0x%08h required=err%0d/0x%08h",
                   b_rerr, b_rdata, e.err, e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1'b1;
    a_valid = 0; a_we = 0; a_addr = 0; a_ctrl = 0; a_wdata = 0;
    b_valid = 0; b_we = 0; b_addr = 0; b_ctrl = 0; b_wdata = 0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", 32'(a_ready), 32'd0);
    check("reset_outputs", {a_rvalid, a_rerr, 30'd0} | a_rdata, 32'd0);
    rst = 1'b0;
    ready_delay(n);
    check("ready_after_reset", n, 32);

    // Cleared array reads zero
    issue(0, 0, 7'h00, 3'b100, 0);
    issue(0, 0, 7'h40, 3'b100, 0);
    issue(0, 0, 7'h7C, 3'b100, 0);

    // Extraction and extension
    issue(0, 1, 7'h08, 3'b100, 32'hDEADBEEF);
    issue(0, 1, 7'h0C, 3'b100, 32'hDEADBEEF);
    issue(0, 0, 7'h09, 3'b000, 0);
    issue(0, 0, 7'h09, 3'b001, 0);
    issue(0, 0, 7'h0A, 3'b010, 0);
    issue(0, 0, 7'h0A, 3'b011, 0);
    // Store byte immediately followed by load of the same word
    issue(0, 1, 7'h0F, 3'b000, 32'h00000011);
    issue(0, 0, 7'h0C, 3'b100, 0);

    // Error cases then verify memory
    issue(0, 0, 7'h05, 3'b010, 0);
    issue(0, 1, 7'h06, 3'b100, 32'hCAFEF00D);
    issue(0, 0, 7'h10, 3'b110, 0);
    issue(0, 1, 7'h10, 3'b111, 32'h55555555);
    issue(0, 0, 7'h04, 3'b100, 0);
    issue(0, 0, 7'h10, 3'b100, 0);

    // Back-to-back loads
    issue(0, 0, 7'h00, 3'b100, 0);
    check("b2b_valid0", 32'(a_rvalid), 32'd1);
    issue(0, 0, 7'h04, 3'b100, 0);
    check("b2b_valid1", 32'(a_rvalid), 32'd1);
    issue(0, 0, 7'h08, 3'b100, 0);
    check("b2b_valid2", 32'(a_rvalid), 32'd1);
    @(posedge clk); #1;
    check("idle_valid", 32'(a_rvalid), 32'd0);
    check("idle_rdata_hold", a_rdata, 32'hDEADBEEF);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      issue(0, 1'($urandom_range(0, 1)), 7'($urandom_range(0, 127)),
            3'($urandom_range(0, 7)), $urandom);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end

    // Reset pulsed mid-sweep restarts the full clear
    issue(0, 1, 7'h20, 3'b100, 32'h12345678);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_model();
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ready_delay(n);
    check("ready_after_midsweep_rst", n, 32);
    issue(0, 0, 7'h20, 3'b100, 0);
    issue(0, 0, 7'h08, 3'b100, 0);

    // Range error on the 16-word instance
    issue(1, 1, 7'h7C, 3'b100, 32'hA5A5A5A5);
    issue(1, 0, 7'h3C, 3'b100, 0);
    issue(1, 1, 7'h3C, 3'b100, 32'h0BADCAFE);
    issue(1, 0, 7'h7C, 3'b100, 0);
    issue(1, 0, 7'h3C, 3'b100, 0);
    issue(1, 0, 7'h3E, 3'b010, 0);

    repeat (3) @(posedge clk);
    #1;
    check("drain_q0", q0.size(), 0);
    check("drain_q1", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
